// File: rtl/dds_sweep_if.sv
// dds_sweep_if -- command/status bundle between a sweep controller and dds_sweep.
//
// Signals:
//   trigger   one-cycle start pulse (used only while the sweep engine is idle)
//   abort     one-cycle stop pulse (used in any state)
//   startInc  first phase increment of the sweep
//   stopInc   endpoint phase increment
//   stepInc   unsigned step magnitude
//   dwell     each value is held for dwell+1 cycles
//   mode      0 single, 1 sawtooth repeat, 2 triangle, 3 same as 0
//   phaseInc  increment fed to the DDS phase accumulator
//   busy      high while a sweep is running
//   sweepDone one-cycle pulse when a single sweep completes
//   endpoint  one-cycle pulse each time stopInc is reached
//
// master: the side issuing commands; slave: the sweep engine.
interface dds_sweep_if #(
  parameter int WIDTH   = 32,
  parameter int DWELL_W = 24
);
  logic               trigger;
  logic               abort;
  logic [WIDTH-1:0]   startInc;
  logic [WIDTH-1:0]   stopInc;
  logic [WIDTH-1:0]   stepInc;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   phaseInc;
  logic               busy;
  logic               sweepDone;
  logic               endpoint;

  modport master (
    output trigger, abort, startInc, stopInc, stepInc, dwell, mode,
    input  phaseInc, busy, sweepDone, endpoint
  );

  modport slave (
    input  trigger, abort, startInc, stopInc, stepInc, dwell, mode,
    output phaseInc, busy, sweepDone, endpoint
  );
endinterface

// File: rtl/dds_sweep.sv
// dds_sweep -- chirp generator producing the phase increment for the DDS core.
//
// On trigger the sweep parameters are captured, then the increment steps from
// startInc toward stopInc in stepInc-sized moves (clamped at the target), each
// value held for dwell+1 cycles. Single-shot, sawtooth and triangle modes.
//
// Ports:
//   clk  system clock (clk60)
//   rst  synchronous active-high reset
//   bus  dds_sweep_if.slave: trigger/abort/parameters in, phaseInc and
//        busy/sweepDone/endpoint status out (all outputs registered)
module dds_sweep #(
  parameter int               WIDTH     = 32,
  parameter int               DWELL_W   = 24,
  parameter logic [WIDTH-1:0] RESET_INC = WIDTH'(100000)
) (
  input  logic        clk,
  input  logic        rst,
  dds_sweep_if.slave  bus
);

  typedef enum logic { S_IDLE = 1'b0, S_RUN = 1'b1 } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_phase;
  logic               r_busy;
  logic               r_done;
  logic               r_endp;
  logic [DWELL_W-1:0] r_cnt;
  // r_dir_up is the direction of the start->stop leg; r_return marks the
  // stop->start leg of a triangle, which runs the opposite way.
  logic               r_dir_up;
  logic               r_return;

  // Parameters captured at trigger; inputs are ignored while running.
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_stop;
  logic [WIDTH-1:0]   r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [1:0]         r_mode;

  // One step from cur toward tgt, computed one bit wider so that a carry or
  // borrow clamps to the target instead of wrapping.
  function automatic logic [WIDTH-1:0] step_to(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] tgt,
    input logic [WIDTH-1:0] stp,
    input logic             up
  );
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    if (up) begin
      if (sum > {1'b0, tgt}) step_to = tgt;
      else                   step_to = sum[WIDTH-1:0];
    end else begin
      if (diff[WIDTH] || (diff[WIDTH-1:0] < tgt)) step_to = tgt;
      else                                        step_to = diff[WIDTH-1:0];
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_phase  <= RESET_INC;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_endp   <= 1'b0;
      r_cnt    <= '0;
      r_dir_up <= 1'b1;
      r_return <= 1'b0;
      r_start  <= '0;
      r_stop   <= '0;
      r_step   <= '0;
      r_dwell  <= '0;
      r_mode   <= 2'd0;
    end else begin
      r_done <= 1'b0;
      r_endp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort takes priority over a simultaneous trigger
          if (!bus.abort && bus.trigger) begin
            r_start  <= bus.startInc;
            r_stop   <= bus.stopInc;
            r_step   <= bus.stepInc;
            r_dwell  <= bus.dwell;
            r_mode   <= bus.mode;
            r_phase  <= bus.startInc;
            r_cnt    <= bus.dwell;
            r_dir_up <= (bus.stopInc >= bus.startInc);
            r_return <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt <= r_dwell;
            if (!r_return && (r_phase == r_stop)) begin
              r_endp <= 1'b1;
              case (r_mode)
                2'd1: r_phase <= r_start;
                2'd2: begin
                  // Turn around immediately so stop is not dwelled twice.
                  // With start==stop there is no return leg; staying on the
                  // outbound leg keeps endpoint pulsing every dwell period.
                  if (r_start != r_stop) begin
                    r_return <= 1'b1;
                    r_phase  <= step_to(r_phase, r_start, r_step, !r_dir_up);
                  end
                end
                default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              endcase
            end else if (r_return && (r_phase == r_start)) begin
              r_return <= 1'b0;
              r_phase  <= step_to(r_phase, r_stop, r_step, r_dir_up);
            end else if (r_return) begin
              r_phase <= step_to(r_phase, r_start, r_step, !r_dir_up);
            end else begin
              r_phase <= step_to(r_phase, r_stop, r_step, r_dir_up);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.phaseInc  = r_phase;
  assign bus.busy      = r_busy;
  assign bus.sweepDone = r_done;
  assign bus.endpoint  = r_endp;

endmodule

// File: tb/tb_dds_sweep.sv
module tb_dds_sweep;

  localparam int          WIDTH     = 32;
  localparam int          DWELL_W   = 24;
  localparam logic [31:0] RESET_INC = 32'd100000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_sweep_if #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) bus ();

  dds_sweep #(.WIDTH(WIDTH), .DWELL_W(DWELL_W), .RESET_INC(RESET_INC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is the list of values it visits (one period for repeating modes);
  // each entry is shown for dwell+1 cycles, endpoint fires after an entry
  // that is the stop value reached on the outbound leg.
  logic [31:0] m_seq[$];
  bit          m_ep[$];
  bit          m_stall;
  bit          m_single;
  int          m_dwell;
  int          m_idx;
  int          m_age;
  logic [31:0] m_phase;
  bit          m_busy, m_done, m_endp;

  task automatic build_seq(input longint s, input longint e, input longint st, input int md);
    longint      v;
    logic [31:0] leg[$];
    m_seq.delete();
    m_ep.delete();
    m_stall = 0;
    v = s;
    leg.push_back(v[31:0]);
    while (v != e && leg.size() < 1000) begin
      if (e > v) begin v = v + st; if (v > e) v = e; end
      else       begin v = v - st; if (v < e) v = e; end
      leg.push_back(v[31:0]);
    end
    if (v != e) begin
      m_stall = 1;
      m_seq.push_back(s[31:0]);
      m_ep.push_back(1'b0);
    end else begin
      foreach (leg[i]) begin
        m_seq.push_back(leg[i]);
        m_ep.push_back(i == leg.size() - 1);
      end
      if (md == 2)
        for (int i = leg.size() - 2; i >= 1; i--) begin
          m_seq.push_back(leg[i]);
          m_ep.push_back(1'b0);
        end
    end
  endtask

  always @(posedge clk) begin
    m_done = 0;
    m_endp = 0;
    if (rst) begin
      m_busy  = 0;
      m_phase = RESET_INC;
    end else if (!m_busy) begin
      if (!bus.abort && bus.trigger) begin
        build_seq(longint'(bus.startInc), longint'(bus.stopInc), longint'(bus.stepInc), int'(bus.mode));
        m_dwell  = int'(bus.dwell);
        m_single = (bus.mode == 2'd0) || (bus.mode == 2'd3);
        m_idx    = 0;
        m_age    = 0;
        m_busy   = 1;
        m_phase  = m_seq[0];
      end
    end else if (bus.abort) begin
      m_busy = 0;
    end else if (m_age < m_dwell) begin
      m_age++;
    end else if (!m_stall) begin
      m_age = 0;
      if (m_ep[m_idx]) m_endp = 1;
      if (m_single && m_idx == m_seq.size() - 1) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_idx   = (m_idx + 1) % m_seq.size();
        m_phase = m_seq[m_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_phaseInc",  bus.phaseInc, m_phase);
      chk("model_busy",      32'(bus.busy), 32'(m_busy));
      chk("model_sweepDone", 32'(bus.sweepDone), 32'(m_done));
      chk("model_endpoint",  32'(bus.endpoint), 32'(m_endp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Leaves the bench in cycle T+1 (first cycle showing startInc).
  task automatic trig(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                      input int dw, input int md);
    $display("txn trigger start=%0h stop=%0h step=%0h dwell=%0d mode=%0d", s, e, st, dw, md);
    bus.startInc = s;
    bus.stopInc  = e;
    bus.stepInc  = st;
    bus.dwell    = DWELL_W'(dw);
    bus.mode     = 2'(md);
    bus.trigger  = 1'b1;
    tick(1);
    bus.trigger  = 1'b0;
  endtask

  task automatic do_abort();
    $display("txn abort");
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.trigger = 0; bus.abort = 0;
    bus.startInc = 0; bus.stopInc = 0; bus.stepInc = 0; bus.dwell = 0; bus.mode = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_phaseInc", bus.phaseInc, RESET_INC);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk_en = 1;
    rst = 1'b0;
    tick(2);

    // single up sweep
    trig(32'd100, 32'd130, 32'd10, 2, 0);
    chk("up_t1", bus.phaseInc, 32'd100);
    chk("up_busy_t1", 32'(bus.busy), 32'd1);
    tick(3);  chk("up_t4", bus.phaseInc, 32'd110);
    tick(6);  chk("up_t10", bus.phaseInc, 32'd130);
    tick(2);  chk("up_busy_t12", 32'(bus.busy), 32'd1);
    tick(1);
    chk("up_busy_t13", 32'(bus.busy), 32'd0);
    chk("up_done_t13", 32'(bus.sweepDone), 32'd1);
    chk("up_endp_t13", 32'(bus.endpoint), 32'd1);
    chk("up_hold_t13", bus.phaseInc, 32'd130);
    tick(2);

    // clamp at the top of the range, no wrap
    trig(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 0, 0);
    tick(1);  chk("ovf_t2", bus.phaseInc, 32'hFFFFFF80);
    tick(1);  chk("ovf_t3", bus.phaseInc, 32'hFFFFFFFF);
    tick(1);  chk("ovf_done", 32'(bus.sweepDone), 32'd1);
    tick(2);

    // down sweep with borrow clamp at zero
    trig(32'd1000, 32'd0, 32'd400, 0, 0);
    tick(2);  chk("down_t3", bus.phaseInc, 32'd200);
    tick(1);  chk("down_t4", bus.phaseInc, 32'd0);
    tick(1);  chk("down_busy_t5", 32'(bus.busy), 32'd0);
    tick(2);

    // triangle
    trig(32'd10, 32'd30, 32'd10, 0, 2);
    tick(3);
    chk("tri_t4", bus.phaseInc, 32'd20);
    chk("tri_endp_t4", 32'(bus.endpoint), 32'd1);
    tick(1);  chk("tri_t5", bus.phaseInc, 32'd10);
    tick(2);  chk("tri_t7", bus.phaseInc, 32'd30);
    tick(5);
    chk("tri_nodone", 32'(bus.sweepDone), 32'd0);
    do_abort();
    tick(2);

    // sawtooth, ignored trigger in RUN, abort
    trig(32'd10, 32'd30, 32'd10, 0, 1);
    bus.startInc = 32'd555;
    bus.trigger  = 1'b1;
    tick(1);
    bus.trigger  = 1'b0;
    chk("saw_ignore_trig", bus.phaseInc, 32'd20);
    do_abort();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hold", bus.phaseInc, 32'd20);
    chk("abort_nodone", 32'(bus.sweepDone), 32'd0);
    bus.trigger = 1'b1;
    do_abort();
    bus.trigger = 1'b0;
    chk("abort_wins_busy", 32'(bus.busy), 32'd0);
    tick(2);

    // sawtooth wrap back to start
    trig(32'd10, 32'd30, 32'd10, 0, 1);
    tick(3);  chk("saw_t4", bus.phaseInc, 32'd10);
    tick(4);
    do_abort();
    tick(1);

    // reset mid-sweep, then a clean sweep
    trig(32'd100, 32'd130, 32'd10, 2, 1);
    tick(4);
    $display("txn reset");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_phase", bus.phaseInc, RESET_INC);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    trig(32'd7, 32'd9, 32'd1, 0, 0);
    chk("rst_clean_t1", bus.phaseInc, 32'd7);
    tick(3);
    chk("rst_clean_done", 32'(bus.sweepDone), 32'd1);
    tick(1);

    // start == stop
    trig(32'd50, 32'd50, 32'd5, 3, 3);
    tick(4);
    chk("eq_m0_done", 32'(bus.sweepDone), 32'd1);
    chk("eq_m0_busy", 32'(bus.busy), 32'd0);
    trig(32'd60, 32'd60, 32'd5, 1, 1);
    tick(2);  chk("eq_m1_endp_a", 32'(bus.endpoint), 32'd1);
    tick(1);  chk("eq_m1_endp_b", 32'(bus.endpoint), 32'd0);
    tick(1);  chk("eq_m1_endp_c", 32'(bus.endpoint), 32'd1);
    do_abort();
    trig(32'd70, 32'd70, 32'd5, 0, 2);
    tick(3);
    chk("eq_m2_endp", 32'(bus.endpoint), 32'd1);
    do_abort();

    // zero step stalls at start
    trig(32'd5, 32'd9, 32'd0, 0, 0);
    tick(6);
    chk("stall_phase", bus.phaseInc, 32'd5);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    do_abort();
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep.md
Name: dds_sweep

Overview:
Frequency-sweep (chirp) generator that drives the 32-bit phase increment consumed by the DDS core, sitting directly upstream of it in the clk60 domain.
Sweep parameters come from command-register writes.
On trigger, it steps the increment from a start value to a stop value in fixed steps, holding each value for a programmable dwell.
Three modes: single-shot, sawtooth repeat and triangle.

Parameters:
WIDTH, 32, phase-increment width
DWELL_W, 24, dwell counter width
RESET_INC, 100000, phaseInc value after reset

Ports:
clk  in  1  system clock (clk60)
rst  in  1  synchronous active-high reset
trigger  in  1  one-cycle start pulse; honoured only in IDLE
abort  in  1  one-cycle stop pulse; honoured in any state
startInc  in  WIDTH  first increment of the sweep
stopInc  in  WIDTH  endpoint increment
stepInc  in  WIDTH  unsigned step magnitude
dwell  in  DWELL_W  each value is held for dwell+1 cycles
mode  in  2  0 single, 1 sawtooth repeat, 2 triangle, 3 treated as 0
phaseInc  out  WIDTH  increment to the DDS phase accumulator
busy  out  1  high while a sweep is running
sweepDone  out  1  one-cycle pulse when a single sweep completes
endpoint  out  1  one-cycle pulse each time stopInc is reached (all modes)

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: state IDLE, phaseInc=RESET_INC, busy=0, sweepDone=0, endpoint=0, dwell counter=0, dir=up.
- Configuration capture:
  - States are IDLE and RUN.
  - trigger in IDLE latches startInc, stopInc, stepInc, dwell and mode into shadow registers.
  - Input changes during RUN have no effect.
- Start latency and dwell timing:
  - Trigger sampled at cycle T: at T+1, phaseInc=startInc, busy=1, cnt=dwell.
  - Each value is held exactly dwell+1 cycles.
  - The next value appears at T+2+dwell.
- Direction:
  - At start, dir=up if stop>=start, else down.
  - In triangle mode, the "outbound" leg runs start→stop and the "return" leg runs stop→start.
- Step computation:
  - Performed when cnt==0 in RUN.
  - Arithmetic is WIDTH+1 bits with no wrap.
  - Toward a higher target: next=phaseInc+step; if next>target (including carry-out), next=target.
  - Toward a lower target: next=phaseInc-step; if there is a borrow or next<target, next=target.
  - cnt reloads with the dwell value.
- Action when cnt==0 and phaseInc==stop (outbound leg):
  - endpoint pulses.
  - mode 0/3: go to IDLE, busy=0, sweepDone pulses that same cycle, phaseInc holds stop.
  - mode 1: phaseInc=start, cnt reload, stay in RUN.
  - mode 2: reverse and step toward start. The stop value is not dwelled twice.
- Triangle return leg: when phaseInc==start and cnt==0 on the return leg, reverse toward stop. No pulse is generated.
- start==stop:
  - mode 0: finishes after one dwell.
  - modes 1/2: hold start indefinitely, with endpoint pulsing every dwell+1 cycles.
- stepInc==0: only clamping moves the value, so the sweep stalls at start until abort. This is legal and is not an error.
- abort:
  - Next cycle: IDLE, busy=0, phaseInc holds its current value, no sweepDone pulse.
  - abort and trigger asserted together in IDLE: abort wins and the trigger is ignored.
- trigger while busy: ignored.
- rst mid-sweep: reset values are restored on the next edge, overriding all other inputs.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Single up sweep: start=100, stop=130, step=10, dwell=2, mode 0 → phaseInc is 100, 110, 120, 130, each for 3 cycles. Then endpoint and sweepDone pulse together, busy falls at the 12th cycle after T+1, and phaseInc stays 130.
- Clamp and overflow: start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80, dwell=0 → phaseInc is FFFFFF00, FFFFFF80, FFFFFFFF, then done. There is no wrap to a small value.
- Down sweep: start=1000, stop=0, step=400, dwell=0, mode 0 → phaseInc is 1000, 600, 200, 0, then done.
- Triangle: start=10, stop=30, step=10, dwell=0, mode 2 → phaseInc is 10, 20, 30, 20, 10, 20, 30, … with an endpoint pulse at each 30 and no sweepDone. Sawtooth (mode 1) with the same values → 10, 20, 30, 10, 20, 30, ….
- Abort and ignored trigger: abort during a mode 1 sweep while phaseInc=20 → next cycle busy=0, phaseInc=20, sweepDone=0. A trigger during RUN with a new startInc has no effect.
- Reset mid-sweep: rst during RUN → phaseInc=100000, busy=0, no pulses. A trigger afterward starts a clean sweep.
